multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Next-generation RV32I control unit for the multicycle datapath.
- Replaces the single-cycle combinational controller with a Moore FSM.
- Sequences fetch, decode, execute, memory and writeback over multiple cycles, and stalls on a memory ready handshake.
- Extends ISA coverage to all RV32I branches, shifts, xor, LUI, AUIPC and JALR.
- Counts retired instructions.

Parameters:
- ALUCTRL_W, 4, width of ALUControl; minimum 4, upper bits zero-filled.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode from IR.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed SrcA < SrcB.
- Ltu  in  1  unsigned SrcA < SrcB.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  read request.
- MemWrite  out  1  write request.
- IRWrite  out  1  IR and OldPC enable.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUControl  out  ALUCTRL_W  ALU operation.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset and output timing
  - Async reset puts the state in FETCH and clears instret and illegal.
  - While reset_n = 0, PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced 0. A reset mid-instruction aborts with no further writes.
  - All outputs are combinational from the current state plus op/funct3/flags. There is no output register.
- ALUControl encoding
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB.
  - ALUOp 10 (R/I-type) selects by funct3. funct3 000 gives sub only when op[5] and funct7b5 are both set. funct3 101 gives sra when funct7b5 is set, otherwise srl.
- States
  - FETCH: MemRead, AdrSrc=0, A=00, B=10, add, ResultSrc=10. IRWrite and PCWrite only when mem_ready. Hold until mem_ready, then go to DECODE.
  - DECODE: A=01, B=01, add. ImmSrc per op: B for branch, J for jal, U for auipc, else I.
  - DECODE dispatch: load/store go to MEMADR; R-type to EXECR; I-ALU to EXECI; jal to JAL; jalr to JALR; branch to BRANCH; lui to LUI; auipc to ALUWB.
  - Any other opcode in DECODE is illegal.
  - MEMADR: A=10, B=01, ImmSrc I (loads) or S (stores), add. op[5]=0 goes to MEMREAD, op[5]=1 to MEMWRITE.
  - MEMREAD: MemRead, AdrSrc=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Then FETCH.
  - MEMWRITE: MemWrite, AdrSrc=1, held until mem_ready. Then FETCH.
  - EXECR: A=10, B=00, ALUOp 10. Then ALUWB.
  - EXECI: A=10, B=01, ImmSrc I, ALUOp 10. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Then FETCH.
  - JALR: A=10, B=01, ImmSrc I, add. Then JAL.
  - JAL: A=01, B=10, add, ResultSrc=00, PCWrite. Then ALUWB.
  - LUI: B=01, ImmSrc U, passB. Then ALUWB.
  - BRANCH: A=10, B=00, sub, ResultSrc=00. Then FETCH.
  - BRANCH PCWrite = taken. Taken by funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu. funct3 010/011 are illegal.
- Retirement
  - instret increments by 1 on each transition into FETCH from a non-FETCH state.
  - instret wraps at 2^CNT_W.
- Illegal instructions (feature off)
  - An illegal opcode or branch funct3 returns to FETCH with no writes.
  - It is not retired.
  - illegal stays 0.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction enters TRAP and sets illegal=1. TRAP drives all enables 0, is not retired, and is held until reset.
- Undefined: the TRAP state is not built; illegal is tied 0 and skip-to-FETCH behaviour applies.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings;
  - ALUOp encodings.
- One sub-module, aludec_w: combinational ALUControl decode parametrised by ALUCTRL_W.

Test Plan:
- add x3,x1,x2 with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB. RegWrite only in cycle 4, ALUControl=0, instret 0→1.
- lw with mem_ready low for 3 cycles in MEMREAD → MemRead/AdrSrc=1 held 4 cycles. MEMWB follows with ResultSrc=01, RegWrite.
- bne with Zero=1 → PCWrite=0. bne with Zero=0 → PCWrite=1. bltu with Ltu=1 → PCWrite=1.
- jalr → JALR, JAL, ALUWB. PCWrite only in JAL. RegWrite only in ALUWB.
- sra (funct3=101, funct7b5=1, R-type) → ALUControl=9. srli → 8. lui → 10 with ImmSrc=100.
- Reset asserted in MEMWRITE → MemWrite drops to 0 immediately and the state becomes FETCH. With CTRL_ILLEGAL_TRAP_EN, opcode 0x7F → illegal=1 and stuck in TRAP until reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and control-field encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_LUI,
    S_BRANCH
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

endpackage

// File: rtl/aludec_w.sv
// rtl/aludec_w.sv - ALU operation decode from ALUOp/funct fields, zero-filled to ALUCTRL_W bits
module aludec_w
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 op_b5,
  input  logic                 funct7b5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [3:0] ctrl;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   ctrl = ALU_ADD;
      ALUOP_SUB:   ctrl = ALU_SUB;
      ALUOP_PASSB: ctrl = ALU_PASSB;
      default: begin
        case (funct3)
          // Only R-type can subtract; bit 30 of an I-type add is immediate data
          3'b000:  ctrl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_control = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle Moore control FSM with instret counter
// Optional CTRL_ILLEGAL_TRAP_EN: illegal instructions park in a sticky TRAP state.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 Ltu,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [CNT_W-1:0]     instret,
  output logic                 illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             pc_write, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]       alu_op;
  logic             taken, bad, skip;

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = !Ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;
    bad       = 1'b0;
    skip      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_JAL: begin
            ImmSrc  = IMM_J;
            state_d = S_JAL;
          end
          OP_AUIPC: begin
            ImmSrc  = IMM_U;
            state_d = S_ALUWB;
          end
          OP_BRANCH: begin
            ImmSrc = IMM_B;
            if (funct3[2:1] == 2'b01) bad = 1'b1;
            else                      state_d = S_BRANCH;
          end
          default: bad = 1'b1;
        endcase
        if (bad) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
          skip    = 1'b1;
`endif
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JAL;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        alu_op  = ALUOP_PASSB;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        alu_op   = ALUOP_SUB;
        pc_write = taken;
        state_d  = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && !skip) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  aludec_w #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  // Write enables drop the instant reset asserts, before the state flop settles
  assign PCWrite  = pc_write  & reset_n;
  assign IRWrite  = ir_write  & reset_n;
  assign MemRead  = mem_read  & reset_n;
  assign MemWrite = mem_write & reset_n;
  assign RegWrite = reg_write & reset_n;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed per-cycle checks of the multicycle controller outputs
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] instret;
  logic        illegal;

  int n_vec = 0;
  int n_bad = 0;

  logic [18:0] obs;
  logic [18:0] e_fetch, e_fetch_wait, e_fetch_rst, e_dec_i, e_aluwb;

  multicycle_controller #(.ALUCTRL_W(4), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .Lt         (Lt),
    .Ltu        (Ltu),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .instret    (instret),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  // Field order: PCWrite AdrSrc MemRead MemWrite IRWrite RegWrite ResultSrc A B ImmSrc ALUControl
  function automatic logic [18:0] pack(input int pcw, input int adr, input int mr, input int mw,
                                       input int irw, input int rw, input int res, input int sa,
                                       input int sb, input int imm, input int alu);
    return {1'(pcw), 1'(adr), 1'(mr), 1'(mw), 1'(irw), 1'(rw),
            2'(res), 2'(sa), 2'(sb), 3'(imm), 4'(alu)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic mr, input logic [18:0] exp);
    mem_ready = mr;
    #1;
    chk(tag, {13'd0, obs}, {13'd0, exp});
    @(posedge clk);
    #2;
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk({tag, ".outs"}, {13'd0, obs}, {13'd0, e_fetch_rst});
    chk({tag, ".instret"}, instret, 32'd0);
    chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    e_fetch      = pack(1, 0, 1, 0, 1, 0, 2, 0, 2, 0, 0);
    e_fetch_wait = pack(0, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0);
    e_fetch_rst  = pack(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
    e_dec_i      = pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    e_aluwb      = pack(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    do_reset("reset");

    set_ir(7'b0110011, 3'b000, 1'b0);
    cyc("add.fetch", 1, e_fetch);
    cyc("add.decode", 1, e_dec_i);
    cyc("add.execr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    cyc("add.aluwb", 1, e_aluwb);
    chk("add.instret", instret, 32'd1);

    set_ir(7'b0000011, 3'b010, 1'b0);
    cyc("lw.fetch_wait", 0, e_fetch_wait);
    cyc("lw.fetch", 1, e_fetch);
    cyc("lw.decode", 1, e_dec_i);
    cyc("lw.memadr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("lw.memread%0d", i), (i == 3), pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw.memwb", 1, pack(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    chk("lw.instret", instret, 32'd2);

    set_ir(7'b1100011, 3'b001, 1'b0);
    Zero = 1'b1;
    cyc("bne_z1.fetch", 1, e_fetch);
    cyc("bne_z1.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    cyc("bne_z1.branch", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
    Zero = 1'b0;
    cyc("bne_z0.fetch", 1, e_fetch);
    cyc("bne_z0.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    cyc("bne_z0.branch", 1, pack(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
    set_ir(7'b1100011, 3'b110, 1'b0);
    Zero = 1'b1;
    Ltu = 1'b1;
    cyc("bltu.fetch", 1, e_fetch);
    cyc("bltu.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    cyc("bltu.branch", 1, pack(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
    Zero = 1'b0;
    Ltu = 1'b0;
    chk("branch.instret", instret, 32'd5);

    set_ir(7'b1100111, 3'b000, 1'b0);
    cyc("jalr.fetch", 1, e_fetch);
    cyc("jalr.decode", 1, e_dec_i);
    cyc("jalr.jalr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    cyc("jalr.jal", 1, pack(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    cyc("jalr.aluwb", 1, e_aluwb);
    chk("jalr.instret", instret, 32'd6);

    set_ir(7'b0110011, 3'b101, 1'b1);
    cyc("sra.fetch", 1, e_fetch);
    cyc("sra.decode", 1, e_dec_i);
    cyc("sra.execr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 9));
    cyc("sra.aluwb", 1, e_aluwb);
    set_ir(7'b0010011, 3'b101, 1'b0);
    cyc("srli.fetch", 1, e_fetch);
    cyc("srli.decode", 1, e_dec_i);
    cyc("srli.execi", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 8));
    cyc("srli.aluwb", 1, e_aluwb);
    set_ir(7'b0110011, 3'b000, 1'b1);
    cyc("sub.fetch", 1, e_fetch);
    cyc("sub.decode", 1, e_dec_i);
    cyc("sub.execr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1));
    cyc("sub.aluwb", 1, e_aluwb);
    set_ir(7'b0010011, 3'b000, 1'b1);
    cyc("addi.fetch", 1, e_fetch);
    cyc("addi.decode", 1, e_dec_i);
    cyc("addi.execi", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    cyc("addi.aluwb", 1, e_aluwb);
    chk("alu.instret", instret, 32'd10);

    set_ir(7'b0110111, 3'b000, 1'b0);
    cyc("lui.fetch", 1, e_fetch);
    cyc("lui.decode", 1, e_dec_i);
    cyc("lui.lui", 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 10));
    cyc("lui.aluwb", 1, e_aluwb);
    set_ir(7'b0010111, 3'b000, 1'b0);
    cyc("auipc.fetch", 1, e_fetch);
    cyc("auipc.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0));
    cyc("auipc.aluwb", 1, e_aluwb);
    set_ir(7'b1101111, 3'b000, 1'b0);
    cyc("jal.fetch", 1, e_fetch);
    cyc("jal.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0));
    cyc("jal.jal", 1, pack(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    cyc("jal.aluwb", 1, e_aluwb);
    chk("upper.instret", instret, 32'd13);

    set_ir(7'b1111111, 3'b000, 1'b0);
    cyc("ill.fetch", 1, e_fetch);
    cyc("ill.decode", 1, e_dec_i);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      cyc($sformatf("ill.trap%0d", i), 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ill.flag", {31'd0, illegal}, 32'd1);
    chk("ill.instret", instret, 32'd13);
`else
    cyc("ill.skip_fetch", 0, e_fetch_wait);
    chk("ill.flag", {31'd0, illegal}, 32'd0);
    chk("ill.instret", instret, 32'd13);
    set_ir(7'b1100011, 3'b010, 1'b0);
    cyc("illbr.fetch", 1, e_fetch);
    cyc("illbr.decode", 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
    cyc("illbr.skip_fetch", 0, e_fetch_wait);
    chk("illbr.instret", instret, 32'd13);
`endif

    do_reset("reset2");

    set_ir(7'b0100011, 3'b010, 1'b0);
    cyc("sw.fetch", 1, e_fetch);
    cyc("sw.decode", 1, e_dec_i);
    cyc("sw.memadr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    cyc("sw.memwrite0", 0, pack(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw.memwrite1", 0, pack(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    #1;
    chk("sw.rst_outs", {13'd0, obs}, {13'd0, e_fetch_rst});
    chk("sw.rst_instret", instret, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    // State must have come back in FETCH: the abandoned store never resumes
    cyc("sw2.fetch", 1, e_fetch);
    cyc("sw2.decode", 1, e_dec_i);
    cyc("sw2.memadr", 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    cyc("sw2.memwrite", 1, pack(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("sw2.instret", instret, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
